// File: rtl/hdlverifier_capture_jtag_readout_if.sv
// Register bus, serial read path and capture-buffer read port between the JTAG
// capture core/buffer (master side) and the readout block (slave side).
interface hdlverifier_capture_jtag_readout_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [4:0]            reg_addr;
  logic [31:0]           reg_wdata;
  logic                  reg_write;
  logic [31:0]           reg_rdata;
  logic                  shift_out_state;
  logic                  shift_out_en;
  logic                  shift_out_data;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  capture_done;
  logic                  capture_arm;

  modport master (
    output reg_addr, reg_wdata, reg_write, shift_out_state, shift_out_en,
           mem_rdata, capture_done,
    input  reg_rdata, shift_out_data, mem_rd_en, mem_raddr, capture_arm
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_write, shift_out_state, shift_out_en,
           mem_rdata, capture_done,
    output reg_rdata, shift_out_data, mem_rd_en, mem_raddr, capture_arm
  );
endinterface

// File: rtl/hdlverifier_capture_jtag_readout.sv
// JTAG capture readout: small register file plus a prefetching word-to-serial
// streamer that feeds capture-buffer words LSB-first to the core's data-read path.
module hdlverifier_capture_jtag_readout #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input logic                           tck,
  input logic                           reset_n,
  hdlverifier_capture_jtag_readout_if.slave bus
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH0,
    S_WAIT0,
    S_PRIME,
    S_STREAM
  } state_t;

  state_t                state, state_nxt;

  logic [ADDR_WIDTH-1:0] rd_start;
  logic [15:0]           rd_len;
  logic                  underrun;
  logic                  arm_q;

  logic                  sos_q;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [15:0]           left;
  logic                  fetch;
  logic                  data_vld_q;
  logic                  refill_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] nxt;
  logic                  nxt_vld;
  logic [CNT_W-1:0]      bitcnt;

  logic                  ctrl_wr;
  logic                  start_cmd;
  logic                  underrun_evt;
  logic                  unused_wdata;

  assign ctrl_wr      = bus.reg_write && (bus.reg_addr == 5'd1);
  assign start_cmd    = (state == S_IDLE) && (state_nxt == S_FETCH0);
  assign underrun_evt = bus.shift_out_en &&
                        (state inside {S_FETCH0, S_WAIT0, S_PRIME});
  assign unused_wdata = ^bus.reg_wdata[31:16];

  assign bus.mem_rd_en      = fetch;
  assign bus.mem_raddr      = ptr;
  assign bus.shift_out_data = shreg[0];
  assign bus.capture_arm    = arm_q;

  // NOTE: every path assigns reg_rdata before the case, so no latch is inferred.
  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_addr)
      5'd0:    bus.reg_rdata = VERSION;
      5'd2:    bus.reg_rdata = {30'd0, underrun, bus.capture_done};
      5'd3:    bus.reg_rdata = 32'(rd_start);
      5'd4:    bus.reg_rdata = {16'd0, rd_len};
      default: bus.reg_rdata = '0;
    endcase
  end

  // Dropping shift_out_state aborts from any state; fetches are gated by left
  // so the read strobe never fires once the command's words are exhausted.
  always_comb begin
    state_nxt = state;
    fetch     = 1'b0;
    if (!bus.shift_out_state) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (!sos_q) state_nxt = S_FETCH0;
        S_FETCH0: begin
          fetch     = (left != '0);
          state_nxt = S_WAIT0;
        end
        S_WAIT0:  state_nxt = S_PRIME;
        S_PRIME:  begin
          fetch     = (left != '0);
          state_nxt = S_STREAM;
        end
        S_STREAM: fetch = refill_q && (left != '0);
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: all flops use non-blocking assignments so each sees pre-edge values.
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      rd_start <= '0;
      rd_len   <= '0;
      underrun <= 1'b0;
      arm_q    <= 1'b0;
    end else begin
      arm_q <= ctrl_wr && bus.reg_wdata[0];
      if (underrun_evt) begin
        underrun <= 1'b1;
      end else if (ctrl_wr && bus.reg_wdata[1]) begin
        underrun <= 1'b0;
      end
      if (bus.reg_write && (bus.reg_addr == 5'd3)) rd_start <= bus.reg_wdata[ADDR_WIDTH-1:0];
      if (bus.reg_write && (bus.reg_addr == 5'd4)) rd_len   <= bus.reg_wdata[15:0];
    end
  end

  // Buffer data is valid the cycle after a fetch; it always lands in nxt first,
  // and PRIME or a word boundary moves it into the shift register.
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      sos_q      <= 1'b0;
      ptr        <= '0;
      left       <= '0;
      data_vld_q <= 1'b0;
      refill_q   <= 1'b0;
      shreg      <= '0;
      nxt        <= '0;
      nxt_vld    <= 1'b0;
      bitcnt     <= '0;
    end else begin
      sos_q      <= bus.shift_out_state;
      data_vld_q <= fetch;
      refill_q   <= 1'b0;

      if (start_cmd) begin
        ptr  <= rd_start;
        left <= rd_len;
      end else if (fetch) begin
        ptr  <= ptr + 1'b1;
        left <= left - 1'b1;
      end

      if (!bus.shift_out_state) begin
        shreg   <= '0;
        nxt     <= '0;
        nxt_vld <= 1'b0;
        bitcnt  <= '0;
      end else begin
        if (state == S_PRIME) begin
          shreg   <= nxt_vld ? nxt : '0;
          nxt_vld <= 1'b0;
          bitcnt  <= '0;
        end else if ((state == S_STREAM) && bus.shift_out_en) begin
          if (bitcnt == LAST_BIT) begin
            shreg    <= nxt_vld ? nxt : '0;
            nxt_vld  <= 1'b0;
            bitcnt   <= '0;
            refill_q <= 1'b1;
          end else begin
            shreg  <= {1'b0, shreg[DATA_WIDTH-1:1]};
            bitcnt <= bitcnt + 1'b1;
          end
        end
        if (data_vld_q) begin
          nxt     <= bus.mem_rdata;
          nxt_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hdlverifier_capture_jtag_readout.sv
// Self-checking bench: random commands streamed from a modelled capture buffer,
// each serial bit compared against the word sequence implied by RD_START/RD_LEN.
module tb_hdlverifier_capture_jtag_readout;

  localparam int          DW      = 32;
  localparam int          AW      = 10;
  localparam int          DEPTH   = 1 << AW;
  localparam logic [31:0] VERSION = 32'h0001_0000;

  logic tck     = 1'b0;
  logic reset_n = 1'b0;
  always #5 tck = ~tck;

  hdlverifier_capture_jtag_readout_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  hdlverifier_capture_jtag_readout #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .VERSION   (VERSION)
  ) dut (
    .tck    (tck),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int n_vec   = 0;
  int n_err   = 0;
  int rd_cnt  = 0;
  int arm_cnt = 0;
  logic [DW-1:0] mem_buf [DEPTH];

  // Capture buffer: data valid exactly one cycle after the read strobe, junk otherwise.
  always @(posedge tck) begin
    if (bus.mem_rd_en) begin
      bus.mem_rdata <= mem_buf[bus.mem_raddr];
      rd_cnt        <= rd_cnt + 1;
    end else begin
      bus.mem_rdata <= $urandom;
    end
    if (bus.capture_arm) arm_cnt <= arm_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge tck);
  endtask

  task automatic reg_wr(input logic [4:0] addr, input logic [31:0] data);
    bus.reg_addr  = addr;
    bus.reg_wdata = data;
    bus.reg_write = 1'b1;
    @(negedge tck);
    bus.reg_write = 1'b0;
  endtask

  task automatic reg_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.reg_addr = addr;
    #1;
    check(tag, bus.reg_rdata, exp);
  endtask

  // Bit k of a command's serial stream: words start..start+len-1 (wrapping), LSB first, then zeros.
  function automatic logic exp_bit(input int start, input int len, input int k);
    int w;
    w = k / DW;
    if (w >= len) return 1'b0;
    return mem_buf[(start + w) % DEPTH][k % DW];
  endfunction

  task automatic run_stream(input int start, input int len, input int n_en,
                            input bit end_cmd, input bit poke, input string tag);
    int          rd0;
    logic [31:0] obs;
    logic [31:0] expw;
    reg_wr(5'd3, 32'(start));
    reg_wr(5'd4, 32'(len));
    rd0 = rd_cnt;
    bus.shift_out_state = 1'b1;
    @(negedge tck);
    if (poke) begin
      bus.shift_out_en = 1'b1;
      @(negedge tck);
      bus.shift_out_en = 1'b0;
      cyc(4);
    end else begin
      cyc(5);
    end
    obs  = '0;
    expw = '0;
    for (int k = 0; k < n_en; k++) begin
      obs[k % DW]  = bus.shift_out_data;
      expw[k % DW] = exp_bit(start, len, k);
      bus.shift_out_en = 1'b1;
      @(negedge tck);
      bus.shift_out_en = 1'b0;
      if ((k % DW == DW - 1) || (k == n_en - 1)) begin
        check($sformatf("%s_w%0d", tag, k / DW), obs, expw);
        obs  = '0;
        expw = '0;
      end
      if (k == 5) reg_wr(5'd3, 32'(start) ^ 32'h155);
      cyc($urandom_range(0, 2));
    end
    if (end_cmd) begin
      bus.shift_out_state = 1'b0;
      cyc(3);
      if (n_en >= len * DW) check({tag, "_rdcnt"}, 32'(rd_cnt - rd0), 32'(len));
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int start;
    int len;
    int n_en;

    bus.reg_addr        = '0;
    bus.reg_wdata       = '0;
    bus.reg_write       = 1'b0;
    bus.shift_out_state = 1'b0;
    bus.shift_out_en    = 1'b0;
    bus.capture_done    = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_buf[i] = $urandom;

    cyc(3);
    check("rst_outputs", {19'd0, bus.mem_rd_en, bus.shift_out_data, bus.capture_arm,
                          bus.mem_raddr}, 32'd0);
    reg_chk("rst_version", 5'd0, VERSION);
    @(negedge tck);
    reset_n = 1'b1;
    cyc(2);

    // Register file
    reg_wr(5'd3, 32'hFFFF_F3FF);
    reg_wr(5'd4, 32'hABCD_0002);
    reg_chk("rd_start", 5'd3, 32'h0000_03FF);
    reg_chk("rd_len",   5'd4, 32'h0000_0002);
    reg_chk("control_rd", 5'd1, 32'd0);
    reg_wr(5'd5, 32'hFFFF_FFFF);
    reg_chk("unlisted_rd", 5'd5, 32'd0);
    reg_chk("rd_start_keep", 5'd3, 32'h0000_03FF);
    bus.capture_done = 1'b1;
    reg_chk("status_done", 5'd2, 32'd1);
    bus.capture_done = 1'b0;
    reg_chk("status_idle", 5'd2, 32'd0);

    a0 = arm_cnt;
    reg_wr(5'd1, 32'd1);
    cyc(5);
    check("arm_pulse", 32'(arm_cnt - a0), 32'd1);

    // Wrapping two-word stream with trailing zeros
    mem_buf[10'h3FF] = 32'hA5A5_0001;
    mem_buf[10'h000] = 32'h1234_5678;
    run_stream(10'h3FF, 2, 80, 1'b1, 1'b0, "wrap");

    // Underrun: enable while still fetching, then clear via CONTROL bit1
    run_stream(100, 1, 40, 1'b1, 1'b1, "undr");
    reg_chk("status_underrun", 5'd2, 32'd2);
    a0 = arm_cnt;
    reg_wr(5'd1, 32'd2);
    reg_chk("status_cleared", 5'd2, 32'd0);
    cyc(3);
    check("arm_none", 32'(arm_cnt - a0), 32'd0);

    // Abort after 10 bits, then restart from RD_START
    run_stream(200, 3, 10, 1'b1, 1'b0, "abort");
    run_stream(200, 3, 3 * DW + 8, 1'b1, 1'b0, "restart");

    // Zero-length command
    run_stream(50, 0, 40, 1'b1, 1'b0, "len0");

    // Random commands, some aborted early
    for (int i = 0; i < 10; i++) begin
      start = ($urandom_range(0, 3) == 0) ? DEPTH - int'($urandom_range(1, 3))
                                          : int'($urandom_range(0, DEPTH - 1));
      len   = $urandom_range(0, 4);
      n_en  = len * DW + int'($urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) n_en = $urandom_range(1, len * DW + 1);
      run_stream(start, len, n_en, 1'b1, 1'b0, $sformatf("rnd%0d", i));
    end

    // Reset dropped mid-stream
    run_stream(5, 3, 40, 1'b0, 1'b0, "prerst");
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_outputs", {19'd0, bus.mem_rd_en, bus.shift_out_data, bus.capture_arm,
                             bus.mem_raddr}, 32'd0);
    bus.shift_out_state = 1'b0;
    @(negedge tck);
    reg_chk("midrst_version", 5'd0, VERSION);
    reg_chk("midrst_rd_start", 5'd3, 32'd0);
    @(negedge tck);
    reset_n = 1'b1;
    cyc(2);
    run_stream(7, 1, 40, 1'b1, 1'b0, "postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
